// File: rtl/add_sub_arbiter_pkg.sv
// add_sub_arbiter_pkg
// Shared ALU definitions used by the add/sub arbiter and its arithmetic core.
//   ALU_WIDTH     : native operand width of the ALU datapath
//   OP_ADD/OP_SUB : encoding of the per-requester add/sub select
//   alu_result_t  : bundle of sum, carry out and signed overflow
package add_sub_arbiter_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] s;
        logic                 c_out;
        logic                 ovf;
    } alu_result_t;

endpackage

// File: rtl/add_sub_arbiter_core.sv
// add_sub_core
// Combinational WIDTH-bit ripple-carry adder/subtractor.
//   a, b  : operands
//   a_s   : op select (OP_ADD / OP_SUB); subtract computes a - b
//   s     : sum or difference, modulo 2^WIDTH
//   c_out : carry out of the MSB (for subtract, 1 means no borrow)
//   ovf   : signed overflow (carry into MSB xor carry out of MSB)
module add_sub_core
    import add_sub_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_s,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    // Subtraction is a + ~b + 1: invert b and inject the select as carry-in.
    // The carry is kept in a single running variable rather than a vector so
    // the chain does not look like a combinational loop; the carry entering
    // the MSB is captured on the way for the overflow flag.
    always_comb begin
        logic             sub;
        logic [WIDTH-1:0] b_eff;
        logic             carry;
        logic             carry_into_msb;
        sub            = (a_s == OP_SUB);
        b_eff          = b ^ {WIDTH{sub}};
        carry          = sub;
        carry_into_msb = 1'b0;
        s              = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                carry_into_msb = carry;
            end
            s[i]  = a[i] ^ b_eff[i] ^ carry;
            carry = (a[i] & b_eff[i]) | (a[i] & carry) | (b_eff[i] & carry);
        end
        c_out = carry;
        ovf   = carry_into_msb ^ carry;
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter
// Round-robin arbiter sharing one adder/subtractor among N_REQ requesters,
// with a single-entry result register drained by a valid/ready handshake.
//   clk, rst            : clock and asynchronous active-high reset
//   req, a_s            : per-requester request level and add/sub select
//   a_bus, b_bus        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt                 : combinational one-hot grant
//   res_valid/res_ready : result handshake
//   res_s, res_c_out, res_ovf, res_tag : registered result and its origin
module add_sub_arbiter
    import add_sub_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int TAG_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       a_s,
    input  logic [N_REQ*WIDTH-1:0] a_bus,
    input  logic [N_REQ*WIDTH-1:0] b_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_s,
    output logic                   res_c_out,
    output logic                   res_ovf,
    output logic [TAG_W-1:0]       res_tag
);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] ptr_next;
    logic             grant_any;
    logic             slot_free;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             a_s_sel;
    logic [WIDTH-1:0] core_s;
    logic             core_c_out;
    logic             core_ovf;

    assign slot_free = !res_valid || res_ready;

    // Round-robin search: walk upward from ptr, wrapping at N_REQ-1, and take
    // the first requester with req set. Nothing is granted while the output
    // slot is blocked or while reset is held. The grant depends only on req
    // and the slot state, never on operands.
    always_comb begin
        int idx;
        gnt       = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (slot_free && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!grant_any && req[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'(idx);
                    gnt[idx]  = 1'b1;
                end
            end
        end
    end

    // The pointer moves to the requester just after the winner, wrapping
    // explicitly so non-power-of-two N_REQ also behaves.
    always_comb begin
        if (grant_idx == TAG_W'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + TAG_W'(1);
        end
    end

    // Operand mux feeding the single shared core with the winner's inputs.
    always_comb begin
        a_sel   = a_bus[int'(grant_idx)*WIDTH +: WIDTH];
        b_sel   = b_bus[int'(grant_idx)*WIDTH +: WIDTH];
        a_s_sel = a_s[grant_idx];
    end

    add_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_sel),
        .b     (b_sel),
        .a_s   (a_s_sel),
        .s     (core_s),
        .c_out (core_c_out),
        .ovf   (core_ovf)
    );

    // Output register and pointer. A grant only happens when the slot is
    // free, so loading on a grant also covers the accept-and-reload case with
    // no bubble. An accept with no grant just drops valid; data is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            res_valid <= 1'b0;
            res_s     <= '0;
            res_c_out <= 1'b0;
            res_ovf   <= 1'b0;
            res_tag   <= '0;
        end else if (grant_any) begin
            ptr       <= ptr_next;
            res_valid <= 1'b1;
            res_s     <= core_s;
            res_c_out <= core_c_out;
            res_ovf   <= core_ovf;
            res_tag   <= grant_idx;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb_add_sub_arbiter
// Directed bench for add_sub_arbiter (N_REQ=4, WIDTH=8). Expected results are
// computed from the driven operands by an independent arithmetic model and
// queued when a grant is seen; they are popped and compared once the result
// register loads.
module tb_add_sub_arbiter;
    import add_sub_arbiter_pkg::*;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int TAG_W = 2;

    typedef struct packed {
        alu_result_t      res;
        logic [TAG_W-1:0] tag;
    } sb_entry_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ-1:0]       a_s = '0;
    logic [N_REQ*WIDTH-1:0] a_bus = '0;
    logic [N_REQ*WIDTH-1:0] b_bus = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [WIDTH-1:0]       res_s;
    logic                   res_c_out;
    logic                   res_ovf;
    logic [TAG_W-1:0]       res_tag;

    int        checks = 0;
    int        errors = 0;
    sb_entry_t sb[$];
    sb_entry_t last_exp = '0;

    add_sub_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_s       (a_s),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
        .res_c_out (res_c_out),
        .res_ovf   (res_ovf),
        .res_tag   (res_tag)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if the clock loop stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference arithmetic: widened sum for carry, sign rule for overflow.
    function automatic alu_result_t model(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
        logic [8:0]  full;
        logic [7:0]  bx;
        alu_result_t r;
        bx      = sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, bx} + {8'd0, sub};
        r.s     = full[7:0];
        r.c_out = full[8];
        r.ovf   = (a[7] == bx[7]) && (full[7] != a[7]);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic set_operands(input int i, input logic [7:0] a, input logic [7:0] b,
                                input logic sub);
        a_bus[i*WIDTH +: WIDTH] = a;
        b_bus[i*WIDTH +: WIDTH] = b;
        a_s[i]                  = sub;
    endtask

    task automatic apply_stimulus(input logic [N_REQ-1:0] r, input logic ready);
        req       = r;
        res_ready = ready;
    endtask

    // One clock: check the combinational grant, queue the expected result of
    // the winner, then after the edge compare the result register against the
    // scoreboard (or against the held value when nothing loaded).
    task automatic run_cycle(input string name, input logic [N_REQ-1:0] exp_gnt,
                             input logic exp_valid);
        sb_entry_t e;
        #1;
        check_output({name, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_gnt[i]) begin
                e.res = model(a_bus[i*WIDTH +: WIDTH], b_bus[i*WIDTH +: WIDTH], a_s[i]);
                e.tag = TAG_W'(i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
        end
        check_output({name, ".valid"}, 32'(res_valid), 32'(exp_valid));
        check_output({name, ".s"},     32'(res_s),     32'(last_exp.res.s));
        check_output({name, ".c_out"}, 32'(res_c_out), 32'(last_exp.res.c_out));
        check_output({name, ".ovf"},   32'(res_ovf),   32'(last_exp.res.ovf));
        check_output({name, ".tag"},   32'(res_tag),   32'(last_exp.tag));
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(4'b1111, 1'b1);
        #1 rst = 1'b1;
        #2;
        check_output("reset.gnt",   32'(gnt),       32'(0));
        check_output("reset.valid", 32'(res_valid), 32'(0));
        check_output("reset.s",     32'(res_s),     32'(0));
        check_output("reset.tag",   32'(res_tag),   32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single add from requester 0: 0x5A + 0x33 = 0x8D, signed overflow.
        set_operands(0, 8'h5A, 8'h33, OP_ADD);
        apply_stimulus(4'b0001, 1'b1);
        run_cycle("add", 4'b0001, 1'b1);
        apply_stimulus(4'b0000, 1'b1);
        run_cycle("drain0", 4'b0000, 1'b0);

        // Subtracts from requester 2, held high for a second operation.
        set_operands(2, 8'h10, 8'h20, OP_SUB);
        apply_stimulus(4'b0100, 1'b1);
        run_cycle("sub1", 4'b0100, 1'b1);
        set_operands(2, 8'h80, 8'h01, OP_SUB);
        run_cycle("sub2", 4'b0100, 1'b1);
        apply_stimulus(4'b0000, 1'b1);
        run_cycle("drain1", 4'b0000, 1'b0);

        // Bring the pointer back to 0, then all four requesting continuously.
        set_operands(0, 8'h01, 8'h02, OP_ADD);
        set_operands(1, 8'h7F, 8'h01, OP_ADD);
        set_operands(2, 8'h00, 8'h01, OP_SUB);
        set_operands(3, 8'hFF, 8'hFF, OP_ADD);
        apply_stimulus(4'b1000, 1'b1);
        run_cycle("rr_pre", 4'b1000, 1'b1);
        apply_stimulus(4'b1111, 1'b1);
        run_cycle("rr0", 4'b0001, 1'b1);
        run_cycle("rr1", 4'b0010, 1'b1);
        run_cycle("rr2", 4'b0100, 1'b1);
        run_cycle("rr3", 4'b1000, 1'b1);
        run_cycle("rr4", 4'b0001, 1'b1);

        // Pointer skip: after a grant to 1, only 0 and 3 request.
        apply_stimulus(4'b0010, 1'b1);
        run_cycle("skip_a", 4'b0010, 1'b1);
        apply_stimulus(4'b1001, 1'b1);
        run_cycle("skip_b", 4'b1000, 1'b1);
        run_cycle("skip_c", 4'b0001, 1'b1);

        // Backpressure: held result, no grants, then accept and reload together.
        apply_stimulus(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_cycle("stall", 4'b0000, 1'b1);
        end
        apply_stimulus(4'b1111, 1'b1);
        run_cycle("release", 4'b0010, 1'b1);

        // Reset in the middle of a pending result clears it without a clock.
        apply_stimulus(4'b1111, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_output("mid_rst.gnt",   32'(gnt),       32'(0));
        check_output("mid_rst.valid", 32'(res_valid), 32'(0));
        check_output("mid_rst.s",     32'(res_s),     32'(0));
        check_output("mid_rst.c_out", 32'(res_c_out), 32'(0));
        check_output("mid_rst.ovf",   32'(res_ovf),   32'(0));
        check_output("mid_rst.tag",   32'(res_tag),   32'(0));
        sb.delete();
        last_exp = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(4'b0110, 1'b1);
        run_cycle("post_rst", 4'b0010, 1'b1);
        apply_stimulus(4'b0000, 1'b1);
        run_cycle("final_drain", 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Round-robin arbiter that shares one 8-bit adder/subtractor among `N_REQ` requesters in the ALU. Each requester presents operands and an add/sub select. The block grants one requester per cycle, computes the result, and holds it in a single-entry output register. The register carries the requester tag and carry/overflow flags, and drains through a valid/ready handshake.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width
- `TAG_W`, `$clog2(N_REQ)`, tag width (derived, not overridden)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req` in `N_REQ`: per-requester request, level
- `a_s` in `N_REQ`: per-requester op select, 0 = add, 1 = subtract (a − b)
- `a_bus` in `N_REQ*WIDTH`: operand A, requester i at `[i*WIDTH +: WIDTH]`
- `b_bus` in `N_REQ*WIDTH`: operand B, same packing
- `gnt` out `N_REQ`: one-hot grant, combinational, at most one bit set
- `res_valid` out 1: output register holds a result
- `res_ready` in 1: consumer accepts result
- `res_s` out `WIDTH`: sum/difference
- `res_c_out` out 1: carry out; for subtract, 1 = no borrow (a ≥ b unsigned)
- `res_ovf` out 1: signed overflow
- `res_tag` out `TAG_W`: index of the requester that produced the result

## Operation
- `slot_free = !res_valid || res_ready`.
- Grant rule: if `slot_free` and any `req` is set, grant the first set `req` searching upward from `ptr`, wrapping at `N_REQ-1`→0. Otherwise `gnt = 0`.
- On a grant to i at a clock edge:
  - The output register loads from the core result for requester i: `s`, `c_out`, `ovf`, tag = i.
  - `res_valid` is set.
  - `ptr` becomes (i+1) mod `N_REQ`.
- On an accepted result with no new grant (`res_valid && res_ready`, no `req`): `res_valid` clears, data holds its last value.
- Arithmetic:
  - Core computes `a + (b ^ {WIDTH{a_s}}) + a_s`.
  - `c_out` is the carry out of the MSB.
  - `ovf` = carry into MSB XOR carry out of MSB.
  - Results wrap modulo 2^WIDTH.
- Requester protocol:
  - The requester holds `req`, `a_s` and operands stable until it sees `gnt[i]`.
  - Operands are sampled on the edge where `gnt[i]` = 1.
  - Keeping `req` high after a grant requests another operation.
- A requester whose `req` is not set never receives `gnt`, even when `ptr` points at it.
- Fairness: with all `req` continuously high, each requester is granted exactly once every `N_REQ` grants.
- Reset values: `ptr` = 0, `res_valid` = 0, `res_s` = 0, `res_c_out` = 0, `res_ovf` = 0, `res_tag` = 0, `gnt` = 0.
- Reset mid-operation: a pending unaccepted result is discarded. No grant is issued while `rst` is high.

## Timing
- Grant to `res_valid`: 1 cycle. The result is visible the cycle after the `gnt` cycle.
- Throughput: 1 operation per cycle while `res_ready` = 1.
- Simultaneous accept and grant in one cycle: the old result drains and the new result loads on the same edge. `res_valid` stays 1 with no bubble.
- Backpressure (`res_valid` = 1, `res_ready` = 0):
  - `gnt` = 0.
  - Output register and `ptr` hold.
  - Outputs are stable until accepted.
- `gnt` depends combinationally on `req`, `res_valid` and `res_ready`. It has no path from `a_bus`, `b_bus` or `a_s`.
- `rst` asserts asynchronously and deasserts synchronously to `clk` at the system level. The first grant may occur in the first cycle after deassertion.

## Structure
- Shared ALU package holds:
  - `ALU_WIDTH` = 8
  - the op encoding constants `OP_ADD` = 0, `OP_SUB` = 1
  - a result struct type (s, c_out, ovf)
- Sub-module `add_sub_core`: combinational `WIDTH`-bit ripple adder with B-inversion by `a_s` and carry-in = `a_s`. Outputs `s`, `c_out`, `ovf`.
  - One instance, fed by a mux selecting the granted requester's operands.
- The round-robin priority search stays inline in `add_sub_arbiter`, together with the output register and `ptr`.

## Test plan
- Single add: req0, a = 0x5A, b = 0x33, `a_s` = 0, `res_ready` = 1 → `gnt` = 0001, next cycle `res_s` = 0x8D, `c_out` = 0, `ovf` = 1, tag = 0.
- Single subtract: req2, a = 0x10, b = 0x20, `a_s` = 1 → `res_s` = 0xF0, `c_out` = 0, `ovf` = 0, tag = 2. Then a = 0x80, b = 0x01 → `res_s` = 0x7F, `c_out` = 1, `ovf` = 1.
- Round-robin: all four `req` high continuously, `res_ready` = 1 → grants 0, 1, 2, 3, 0 on consecutive cycles; tags follow one cycle later with no bubbles.
- Pointer skip: after a grant to 1, `req` = 1001 → next grant is 3, then 0.
- Backpressure: result valid with `res_ready` = 0 for 5 cycles while `req` = 1111 → `gnt` = 0 and outputs unchanged. Raising `res_ready` gives an accept and a new grant on the same edge.
- Reset mid-stream: assert `rst` with `res_valid` = 1 → all outputs 0 immediately, without waiting for a clock. After release, first grant goes to the lowest set `req` (`ptr` = 0).
